// File: rtl/l2_flush_sequencer.sv
// L2 flush sequencer: walks every set/way, probes each line, evicts eligible lines, drains MSHRs.
// Optional eviction counter port evict_cnt is enabled by defining L2_FLUSH_STATS_EN.
module l2_flush_sequencer #(
  parameter int unsigned SETS     = 256,
  parameter int unsigned WAYS     = 8,
  parameter int unsigned SET_BITS = $clog2(SETS),
  parameter int unsigned WAY_BITS = $clog2(WAYS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush_valid,
  input  logic                flush_i,
  output logic                flush_ready,
  input  logic                fwd_pending,
  output logic                rd_req_valid,
  input  logic                rd_rsp_valid,
  input  logic                rd_line_valid,
  input  logic                rd_hprot,
  output logic                evict_valid,
  input  logic                evict_ready,
  input  logic                mshr_full,
  input  logic                mshr_empty,
  output logic [SET_BITS-1:0] flush_set,
  output logic [WAY_BITS-1:0] flush_way,
  output logic                ongoing_flush,
  output logic                flush_done
`ifdef L2_FLUSH_STATS_EN
  ,
  output logic [15:0]         evict_cnt
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    PROBE,
    CHECK,
    EVICT,
    DRAIN,
    DONE
  } state_t;

  state_t              state_q;
  logic                flush_all_q;

  logic                accept_c;
  logic                eligible_c;
  logic                last_way_c;
  logic                last_line_c;
  logic                advance_c;
  logic                evict_fire_c;
  logic [SET_BITS-1:0] nxt_set_c;
  logic [WAY_BITS-1:0] nxt_way_c;

  // Next set/way of the walk and the conditions that move it forward.
  always_comb begin
    accept_c     = (state_q == IDLE) && flush_valid && flush_ready;
    eligible_c   = rd_line_valid && (flush_all_q || rd_hprot);
    evict_fire_c = (state_q == EVICT) && evict_valid && evict_ready;
    last_way_c   = (flush_way == WAY_BITS'(WAYS - 1));
    last_line_c  = last_way_c && (flush_set == SET_BITS'(SETS - 1));
    nxt_way_c    = last_way_c ? '0 : flush_way + WAY_BITS'(1);
    nxt_set_c    = last_way_c ? flush_set + SET_BITS'(1) : flush_set;
    advance_c    = ((state_q == CHECK) && rd_rsp_valid && !eligible_c) || evict_fire_c;
  end

  // Walk FSM; every output is a register updated here. Probe/evict requests are
  // raised one edge ahead using the stall inputs sampled at that edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      flush_all_q   <= 1'b0;
      flush_ready   <= 1'b0;
      rd_req_valid  <= 1'b0;
      evict_valid   <= 1'b0;
      flush_set     <= '0;
      flush_way     <= '0;
      ongoing_flush <= 1'b0;
      flush_done    <= 1'b0;
`ifdef L2_FLUSH_STATS_EN
      evict_cnt     <= '0;
`endif
    end else begin
      flush_done <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept_c) begin
            flush_all_q   <= flush_i;
            flush_set     <= '0;
            flush_way     <= '0;
            ongoing_flush <= 1'b1;
            flush_ready   <= 1'b0;
            rd_req_valid  <= !fwd_pending;
            state_q       <= PROBE;
          end else begin
            flush_ready <= 1'b1;
          end
        end
        PROBE: begin
          if (rd_req_valid) begin
            rd_req_valid <= 1'b0;
            state_q      <= CHECK;
          end else begin
            rd_req_valid <= !fwd_pending;
          end
        end
        CHECK: begin
          if (rd_rsp_valid && eligible_c) begin
            evict_valid <= !mshr_full && !fwd_pending;
            state_q     <= EVICT;
          end
        end
        EVICT: begin
          if (!evict_valid) begin
            evict_valid <= !mshr_full && !fwd_pending;
          end else if (evict_ready) begin
            evict_valid <= 1'b0;
          end
        end
        DRAIN: begin
          if (mshr_empty) begin
            flush_done <= 1'b1;
            state_q    <= DONE;
          end
        end
        DONE: begin
          ongoing_flush <= 1'b0;
          flush_ready   <= 1'b1;
          state_q       <= IDLE;
        end
        default: state_q <= IDLE;
      endcase

      // Step to the next line, or to the drain once the final line is done.
      if (advance_c) begin
        flush_set    <= nxt_set_c;
        flush_way    <= nxt_way_c;
        rd_req_valid <= !last_line_c && !fwd_pending;
        state_q      <= last_line_c ? DRAIN : PROBE;
      end

`ifdef L2_FLUSH_STATS_EN
      if (accept_c) begin
        evict_cnt <= '0;
      end else if (evict_fire_c && (evict_cnt != 16'hFFFF)) begin
        evict_cnt <= evict_cnt + 16'd1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_l2_flush_sequencer.sv
// Directed bench for l2_flush_sequencer with SETS=4, WAYS=2 and a 1-cycle probe responder.
module tb_l2_flush_sequencer;
  localparam int unsigned SETS = 4;
  localparam int unsigned WAYS = 2;
  localparam int unsigned SET_BITS = 2;
  localparam int unsigned WAY_BITS = 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush_valid = 1'b0, flush_i = 1'b0, flush_ready;
  logic fwd_pending = 1'b0;
  logic rd_req_valid, rd_rsp_valid = 1'b0, rd_line_valid, rd_hprot;
  logic evict_valid, evict_ready = 1'b1, mshr_full = 1'b0, mshr_empty = 1'b1;
  logic [SET_BITS-1:0] flush_set;
  logic [WAY_BITS-1:0] flush_way;
  logic ongoing_flush, flush_done;
`ifdef L2_FLUSH_STATS_EN
  logic [15:0] evict_cnt;
`endif

  logic [7:0] line_v = 8'h00;
  logic [7:0] line_h = 8'h00;
  logic       req_prev = 1'b0;
  int errors = 0;
  int checks = 0;

  l2_flush_sequencer #(.SETS(SETS), .WAYS(WAYS), .SET_BITS(SET_BITS), .WAY_BITS(WAY_BITS)) dut (
    .clk(clk), .rst(rst),
    .flush_valid(flush_valid), .flush_i(flush_i), .flush_ready(flush_ready),
    .fwd_pending(fwd_pending),
    .rd_req_valid(rd_req_valid), .rd_rsp_valid(rd_rsp_valid),
    .rd_line_valid(rd_line_valid), .rd_hprot(rd_hprot),
    .evict_valid(evict_valid), .evict_ready(evict_ready),
    .mshr_full(mshr_full), .mshr_empty(mshr_empty),
    .flush_set(flush_set), .flush_way(flush_way),
    .ongoing_flush(ongoing_flush), .flush_done(flush_done)
`ifdef L2_FLUSH_STATS_EN
    , .evict_cnt(evict_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Tag-state memory model: line contents indexed by the current set/way, response one cycle after request.
  assign rd_line_valid = line_v[{flush_set, flush_way}];
  assign rd_hprot      = line_h[{flush_set, flush_way}];
  always @(posedge clk) begin
    #1;
    rd_rsp_valid = req_prev;
    req_prev     = rd_req_valid;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Hand a flush to the DUT from IDLE; returns in the first PROBE cycle.
  task automatic start_flush(input logic mode);
    flush_i     = mode;
    flush_valid = 1'b1;
    tick;
    flush_valid = 1'b0;
  endtask

  task automatic run_until_done(input int budget, output int cyc);
    cyc = 0;
    while (flush_done !== 1'b1 && cyc <= budget) begin
      tick;
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    tick;
    checks++;
    if ({flush_set, flush_way, rd_req_valid, evict_valid, ongoing_flush, flush_done, flush_ready} !== 9'b0) begin
      errors++;
      $display("FAIL reset_outputs: got set=%0d way=%0d req=%b ev=%b ong=%b done=%b rdy=%b, expected all 0",
               flush_set, flush_way, rd_req_valid, evict_valid, ongoing_flush, flush_done, flush_ready);
    end
`ifdef L2_FLUSH_STATS_EN
    checks++;
    if (evict_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_evict_cnt: got %0d expected 0", evict_cnt);
    end
`endif
    rst = 1'b0;
    #1;
    checks++;
    if (flush_ready !== 1'b0) begin
      errors++;
      $display("FAIL ready_before_clock: got %b expected 0", flush_ready);
    end
    tick;
    checks++;
    if (flush_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_clock: got %b expected 1", flush_ready);
    end
  endtask

  task automatic test_empty_walk;
    int n_req = 0, n_ev = 0, done_cyc = 0;
    logic [2:0] exp_loc;
    line_v = 8'h00;
    start_flush(1'b1);
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      if (rd_req_valid === 1'b1) begin
        exp_loc = 3'(n_req);
        checks++;
        if ({flush_set, flush_way} !== exp_loc) begin
          errors++;
          $display("FAIL walk_order: probe %0d at set=%0d way=%0d expected set=%0d way=%0d",
                   n_req, flush_set, flush_way, n_req / 2, n_req % 2);
        end
        n_req++;
      end
      if (evict_valid === 1'b1) n_ev++;
      if (flush_done === 1'b1) done_cyc = c;
      tick;
    end
    checks++;
    if (n_req != 8) begin
      errors++;
      $display("FAIL walk_probe_count: got %0d expected 8", n_req);
    end
    checks++;
    if (n_ev != 0) begin
      errors++;
      $display("FAIL walk_no_evict: got %0d evict cycles expected 0", n_ev);
    end
    checks++;
    if (done_cyc != 18) begin
      errors++;
      $display("FAIL walk_done_cycle: got %0d expected 18", done_cyc);
    end
    checks++;
    if ({flush_done, ongoing_flush, flush_ready} !== 3'b001) begin
      errors++;
      $display("FAIL walk_back_idle: got done=%b ong=%b rdy=%b expected 0/0/1", flush_done, ongoing_flush, flush_ready);
    end
  endtask

  task automatic test_hprot_filter;
    int n_ev = 0, done_cyc = 0;
    logic [2:0] ev_loc = 3'b111;
    line_v = 8'h00;
    line_h = 8'h00;
    line_v[5] = 1'b1;
    line_v[2] = 1'b1;
    line_h[2] = 1'b1;
    start_flush(1'b0);
    for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
      if (evict_valid === 1'b1 && evict_ready === 1'b1) begin
        n_ev++;
        ev_loc = {flush_set, flush_way};
      end
      if (flush_done === 1'b1) done_cyc = c;
      tick;
    end
    checks++;
    if (n_ev != 1) begin
      errors++;
      $display("FAIL hprot_evict_count: got %0d expected 1", n_ev);
    end
    checks++;
    if (ev_loc !== 3'b010) begin
      errors++;
      $display("FAIL hprot_evict_loc: got set=%0d way=%0d expected set=1 way=0", ev_loc[2:1], ev_loc[0]);
    end
    checks++;
    if (done_cyc != 19) begin
      errors++;
      $display("FAIL hprot_done_cycle: got %0d expected 19", done_cyc);
    end
`ifdef L2_FLUSH_STATS_EN
    checks++;
    if (evict_cnt !== 16'd1) begin
      errors++;
      $display("FAIL hprot_evict_cnt: got %0d expected 1", evict_cnt);
    end
`endif
    line_h = 8'h00;
  endtask

  task automatic test_evict_stall;
    int cyc;
    line_v = 8'b0000_0010;
    evict_ready = 1'b0;
    start_flush(1'b1);
    repeat (4) tick;
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if ({evict_valid, flush_set, flush_way} !== 4'b1_00_1) begin
        errors++;
        $display("FAIL stall_hold_%0d: got ev=%b set=%0d way=%0d expected ev=1 set=0 way=1",
                 i, evict_valid, flush_set, flush_way);
      end
      tick;
    end
    evict_ready = 1'b1;
    checks++;
    if ({evict_valid, flush_set, flush_way} !== 4'b1_00_1) begin
      errors++;
      $display("FAIL stall_accept_cycle: got ev=%b set=%0d way=%0d expected ev=1 set=0 way=1",
               evict_valid, flush_set, flush_way);
    end
    tick;
    checks++;
    if ({rd_req_valid, evict_valid, flush_set, flush_way} !== 5'b1_0_01_0) begin
      errors++;
      $display("FAIL stall_next_probe: got req=%b ev=%b set=%0d way=%0d expected req=1 ev=0 set=1 way=0",
               rd_req_valid, evict_valid, flush_set, flush_way);
    end
    run_until_done(40, cyc);
    checks++;
    if (cyc > 40) begin
      errors++;
      $display("FAIL stall_done_timeout: waited %0d cycles expected done within 40", cyc);
    end
    tick;
  endtask

  task automatic test_evict_gate;
    int cyc;
    for (int mode = 0; mode < 2; mode++) begin
      line_v = 8'b0000_0001;
      if (mode == 0) mshr_full = 1'b1;
      start_flush(1'b1);
      tick;
      if (mode == 1) fwd_pending = 1'b1;
      tick;
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (evict_valid !== 1'b0) begin
          errors++;
          $display("FAIL gate_blocked_m%0d_%0d: got ev=%b expected 0", mode, i, evict_valid);
        end
        tick;
      end
      mshr_full   = 1'b0;
      fwd_pending = 1'b0;
      tick;
      checks++;
      if ({evict_valid, flush_set, flush_way} !== 4'b1_00_0) begin
        errors++;
        $display("FAIL gate_release_m%0d: got ev=%b set=%0d way=%0d expected ev=1 set=0 way=0",
                 mode, evict_valid, flush_set, flush_way);
      end
      run_until_done(40, cyc);
      checks++;
      if (cyc > 40) begin
        errors++;
        $display("FAIL gate_done_timeout_m%0d: waited %0d cycles expected done within 40", mode, cyc);
      end
      tick;
    end
  endtask

  task automatic test_probe_yield;
    int cyc;
    line_v = 8'h00;
    start_flush(1'b1);
    tick;
    fwd_pending = 1'b1;
    tick;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rd_req_valid, flush_set, flush_way} !== 4'b0_00_1) begin
        errors++;
        $display("FAIL yield_hold_%0d: got req=%b set=%0d way=%0d expected req=0 set=0 way=1",
                 i, rd_req_valid, flush_set, flush_way);
      end
      tick;
    end
    fwd_pending = 1'b0;
    tick;
    checks++;
    if ({rd_req_valid, flush_set, flush_way} !== 4'b1_00_1) begin
      errors++;
      $display("FAIL yield_release: got req=%b set=%0d way=%0d expected req=1 set=0 way=1",
               rd_req_valid, flush_set, flush_way);
    end
    fwd_pending = 1'b1;
    tick;
    tick;
    checks++;
    if ({rd_req_valid, flush_set, flush_way} !== 4'b0_01_0) begin
      errors++;
      $display("FAIL yield_second_hold: got req=%b set=%0d way=%0d expected req=0 set=1 way=0",
               rd_req_valid, flush_set, flush_way);
    end
    fwd_pending = 1'b0;
    tick;
    checks++;
    if ({rd_req_valid, flush_set, flush_way} !== 4'b1_01_0) begin
      errors++;
      $display("FAIL yield_second_release: got req=%b set=%0d way=%0d expected req=1 set=1 way=0",
               rd_req_valid, flush_set, flush_way);
    end
    run_until_done(40, cyc);
    checks++;
    if (cyc > 40) begin
      errors++;
      $display("FAIL yield_done_timeout: waited %0d cycles expected done within 40", cyc);
    end
    tick;
  endtask

  task automatic test_drain;
    line_v = 8'h00;
    mshr_empty = 1'b0;
    start_flush(1'b1);
    repeat (16) tick;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({flush_done, ongoing_flush} !== 2'b01) begin
        errors++;
        $display("FAIL drain_wait_%0d: got done=%b ong=%b expected done=0 ong=1", i, flush_done, ongoing_flush);
      end
      tick;
    end
    mshr_empty = 1'b1;
    tick;
    checks++;
    if (flush_done !== 1'b1) begin
      errors++;
      $display("FAIL drain_pulse: got done=%b expected 1", flush_done);
    end
    tick;
    checks++;
    if ({flush_done, ongoing_flush, flush_ready} !== 3'b001) begin
      errors++;
      $display("FAIL drain_after_pulse: got done=%b ong=%b rdy=%b expected 0/0/1", flush_done, ongoing_flush, flush_ready);
    end
  endtask

  task automatic test_reset_mid_flush;
    int cyc;
    logic seen = 1'b0;
    logic spurious = 1'b0;
    line_v = 8'b0000_1000;
    evict_ready = 1'b0;
    start_flush(1'b1);
    for (int c = 0; c < 20 && !seen; c++) begin
      if (evict_valid === 1'b1) seen = 1'b1;
      else tick;
    end
    checks++;
    if (seen !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_reach_evict: got evict_valid never, expected 1 within 20 cycles");
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({flush_set, flush_way, rd_req_valid, evict_valid, ongoing_flush, flush_done, flush_ready} !== 9'b0) begin
      errors++;
      $display("FAIL rstmid_outputs: got set=%0d way=%0d req=%b ev=%b ong=%b done=%b rdy=%b expected all 0",
               flush_set, flush_way, rd_req_valid, evict_valid, ongoing_flush, flush_done, flush_ready);
    end
    tick;
    rst = 1'b0;
    evict_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (flush_done !== 1'b0 || ongoing_flush !== 1'b0) spurious = 1'b1;
      tick;
    end
    checks++;
    if (spurious !== 1'b0) begin
      errors++;
      $display("FAIL rstmid_no_done: got done/ongoing activity after reset, expected none");
    end
    line_v = 8'h00;
    start_flush(1'b1);
    checks++;
    if ({rd_req_valid, flush_set, flush_way} !== 4'b1_00_0) begin
      errors++;
      $display("FAIL rstmid_restart: got req=%b set=%0d way=%0d expected req=1 set=0 way=0",
               rd_req_valid, flush_set, flush_way);
    end
    run_until_done(40, cyc);
    checks++;
    if (cyc > 40) begin
      errors++;
      $display("FAIL rstmid_done_timeout: waited %0d cycles expected done within 40", cyc);
    end
    tick;
  endtask

  initial begin
    #2;
    test_reset;
    test_empty_walk;
    test_hprot_filter;
    test_evict_stall;
    test_evict_gate;
    test_probe_yield;
    test_drain;
    test_reset_mid_flush;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
